axis_elastic_fifo: RTL and testbench
====================================

// Module: axis_elastic_fifo
// PURPOSE
//   Parametrised successor to the single-slot skid stage: DEPTH-entry AXI-Stream
//   elastic FIFO carrying data plus a packet-boundary flag (last).
//   Sits between the packet mover's ingress/egress stages. Absorbs multi-beat
//   stalls, fully decouples ready timing and reports fill level and stored
//   complete-packet count to the mover's scheduler.
// PARAMETERS
//   DATA_W       32  width of the data payload, in bits
//   DEPTH        4   number of storage entries; power of two, >= 2
//   AFULL_THRESH 3   almost_full asserts when level >= AFULL_THRESH; range 1..DEPTH
// PORTS
//   clk          in   1                    single clock; all logic on rising edge
//   rst          in   1                    synchronous, active-high reset
//   s_valid      in   1                    upstream beat valid
//   s_ready      out  1                    FIFO can accept a beat
//   s_data       in   DATA_W               upstream payload
//   s_last       in   1                    upstream beat is the final beat of a packet
//   m_valid      out  1                    downstream beat valid
//   m_ready      in   1                    downstream accepts the beat
//   m_data       out  DATA_W               downstream payload (head entry)
//   m_last       out  1                    head entry is the final beat of a packet
//   level        out  $clog2(DEPTH+1)      number of entries currently stored
//   almost_full  out  1                    level >= AFULL_THRESH
//   pkt_count    out  $clog2(DEPTH+1)      stored entries with last=1
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-high.
//   - Reset (rst=1 at an edge):
//       rd_ptr = wr_ptr = level = pkt_count = 0.
//       Outputs: m_valid=0, s_ready=1, almost_full=0.
//       Storage contents are don't-care; m_data/m_last carry no meaning while m_valid=0.
//       Reset mid-packet discards all stored beats. No partial state survives.
//   - Handshakes: push = s_valid & s_ready; pop = m_valid & m_ready.
//   - Combinational-path rules:
//       s_ready = (level != DEPTH); it depends only on registered state.
//       m_valid = (level != 0); it depends only on registered state.
//       There is no combinational path from m_ready to s_ready, or from s_valid to m_valid.
//   - Latency: a beat pushed into an empty FIFO appears on m_valid/m_data on the
//     next cycle (1 cycle). Beats are never passed through combinationally.
//   - Ordering: strict FIFO. m_data/m_last always show mem[rd_ptr].
//   - AXIS stability: while m_valid=1 and m_ready=0, m_data and m_last hold steady.
//   - Pointers: log2(DEPTH) bits; they wrap naturally from DEPTH-1 to 0.
//     Full and empty are distinguished by level, not by the pointers.
//   - Level update per edge:
//       push only: +1
//       pop only: -1
//       push and pop together: unchanged
//       Level never exceeds DEPTH and never goes below 0.
//   - Full (level=DEPTH): s_ready=0, even if m_ready=1 in the same cycle.
//     No same-cycle refill at full. The freed slot is offered on the next cycle.
//   - Empty (level=0): m_valid=0. A push while empty gives no same-cycle output.
//   - pkt_count update per edge:
//       +1 on a push with s_last=1
//       -1 on a pop with m_last=1
//       both in the same cycle: unchanged
//   - almost_full is registered, derived from the next-state level; it switches
//     in the same cycle as level.
//   - s_valid while s_ready=0 is legal. The beat is not taken, and upstream holds it.
// TESTING
//   1. Reset, DEPTH=4. Push 0xA1 with m_ready=1. Expect m_valid=1 and
//      m_data=0xA1 on the next cycle; level goes 1 then 0.
//   2. m_ready=0; push 0x10..0x13. Expect:
//        s_ready=0 after the 4th push, level=4, almost_full=1 from level 3.
//        A 5th beat 0x14 held with s_valid=1 is not accepted.
//      Then m_ready=1: expect 0x10,0x11,0x12,0x13,0x14 in order, with no loss or duplication.
//   3. At full, assert m_ready=1 and s_valid=1 in the same cycle.
//      Expect a pop only (level 4->3) and s_ready=0 during that cycle.
//      The next cycle accepts the push.
//   4. Half full: continuous push+pop for 20 cycles. Expect level constant at 2.
//      After the pointers wrap 5 times, the data sequence is intact.
//   5. Push packets {3 beats, last on the 3rd} and {1 beat, last}. Expect:
//        pkt_count=2.
//        After popping 3 beats, pkt_count=1.
//        A simultaneous last-push and last-pop leaves it unchanged.
//   6. With level=3 mid-packet, assert rst=1 for 1 cycle. Expect:
//        Next cycle: m_valid=0, s_ready=1, level=0, pkt_count=0, almost_full=0.
//        The first beat after reset comes out first.

Source files
------------

// File: rtl/axis_elastic_fifo.sv
// rtl/axis_elastic_fifo.sv - DEPTH-entry AXI-Stream elastic FIFO with packet-boundary tracking
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   s_valid/s_ready       upstream handshake; s_data/s_last carry the beat
//   m_valid/m_ready       downstream handshake; m_data/m_last show the head entry
//   level                 number of stored entries
//   almost_full           registered, level >= AFULL_THRESH
//   pkt_count             stored entries whose last flag is set
module axis_elastic_fifo #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_last,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] pkt_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AFULL_LVL = LVL_W'(AFULL_THRESH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic              mem_last [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_next;
    logic [LVL_W-1:0]  pkt_next;
    logic              push;
    logic              pop;

    // Both ready and valid come from registered level only, so the two
    // sides never see each other's handshake combinationally.
    assign s_ready = (level != FULL_LVL);
    assign m_valid = (level != '0);
    assign m_data  = mem_data[rd_ptr];
    assign m_last  = mem_last[rd_ptr];

    assign push = s_valid & s_ready;
    assign pop  = m_valid & m_ready;

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
    end

    always_comb begin
        pkt_next = pkt_count;
        case ({push & s_last, pop & m_last})
            2'b10:   pkt_next = pkt_count + LVL_W'(1);
            2'b01:   pkt_next = pkt_count - LVL_W'(1);
            default: pkt_next = pkt_count;
        endcase
    end

    // Storage needs no reset; entries are only observed while counted in level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= s_data;
            mem_last[wr_ptr] <= s_last;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            pkt_count   <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level       <= level_next;
            pkt_count   <= pkt_next;
            almost_full <= (level_next >= AFULL_LVL);
        end
    end

endmodule

// File: tb/tb_axis_elastic_fifo.sv
// tb/tb_axis_elastic_fifo.sv - directed scoreboard bench for axis_elastic_fifo
module tb_axis_elastic_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_last;
    logic [2:0]  level;
    logic        almost_full;
    logic [2:0]  pkt_count;

    int tests = 0;
    int fails = 0;
    logic [32:0] sb [$];

    axis_elastic_fifo #(.DATA_W(32), .DEPTH(4), .AFULL_THRESH(3)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .level(level), .almost_full(almost_full), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_ready = 1'b1;
        while (m_valid && n < 20) begin
            step();
            n++;
        end
        chk("drain_done", {63'd0, m_valid}, 64'd0);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Mid-cycle scoreboard: handshakes seen here complete at the next edge.
    always @(negedge clk) begin
        logic [32:0] exp;
        if (!rst) begin
            if (m_valid && m_ready) begin
                chk("pop_has_expected", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    chk("pop_beat", {31'd0, m_last, m_data}, {31'd0, exp});
                end
            end
            if (s_valid && s_ready) sb.push_back({s_last, s_data});
        end
    end

    initial begin
        // reset
        step(); step();
        rst = 1'b0;
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
        chk("rst_level", {61'd0, level}, 64'd0);
        chk("rst_pkt", {61'd0, pkt_count}, 64'd0);
        chk("rst_afull", {63'd0, almost_full}, 64'd0);

        // 1: single beat latency
        s_valid = 1'b1; s_data = 32'hA1; m_ready = 1'b1;
        chk("t1_no_passthru", {63'd0, m_valid}, 64'd0);
        step();
        s_valid = 1'b0;
        chk("t1_m_valid", {63'd0, m_valid}, 64'd1);
        chk("t1_m_data", {32'd0, m_data}, 64'hA1);
        chk("t1_level1", {61'd0, level}, 64'd1);
        step();
        chk("t1_level0", {61'd0, level}, 64'd0);
        chk("t1_empty", {63'd0, m_valid}, 64'd0);

        // 2: fill, hold 5th beat, drain in order
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 32'h10 + 32'(i);
            step();
            chk("t2_level", {61'd0, level}, 64'(i + 1));
            chk("t2_afull", {63'd0, almost_full}, {63'd0, (i + 1) >= 3});
        end
        chk("t2_full_s_ready", {63'd0, s_ready}, 64'd0);
        s_data = 32'h14;
        step();
        chk("t2_held_level", {61'd0, level}, 64'd4);
        m_ready = 1'b1;
        step();
        chk("t2_pop_level", {61'd0, level}, 64'd3);
        step();
        s_valid = 1'b0;
        chk("t2_refill_level", {61'd0, level}, 64'd3);
        drain();

        // 3: full with simultaneous ready/valid
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 32'h20 + 32'(i);
            step();
        end
        s_data = 32'h24; m_ready = 1'b1;
        chk("t3_s_ready_full", {63'd0, s_ready}, 64'd0);
        step();
        chk("t3_pop_only", {61'd0, level}, 64'd3);
        chk("t3_s_ready_next", {63'd0, s_ready}, 64'd1);
        step();
        s_valid = 1'b0;
        chk("t3_push_pop", {61'd0, level}, 64'd3);
        drain();

        // 4: half-full streaming, pointers wrap 5 times
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = 32'h30 + 32'(i);
            step();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = 32'h32 + 32'(i);
            step();
            chk("t4_level", {61'd0, level}, 64'd2);
        end
        s_valid = 1'b0;
        drain();

        // 5: packet counting
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 32'h40 + 32'(i); s_last = (i >= 2);
            step();
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("t5_pkt2", {61'd0, pkt_count}, 64'd2);
        m_ready = 1'b1;
        step(); step(); step();
        chk("t5_pkt1", {61'd0, pkt_count}, 64'd1);
        chk("t5_head_last", {63'd0, m_last}, 64'd1);
        s_valid = 1'b1; s_data = 32'h44; s_last = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        chk("t5_pkt_same", {61'd0, pkt_count}, 64'd1);
        drain();
        chk("t5_pkt0", {61'd0, pkt_count}, 64'd0);

        // 6: reset mid-packet
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 32'h50 + 32'(i);
            step();
        end
        s_valid = 1'b0;
        chk("t6_level3", {61'd0, level}, 64'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        chk("t6_m_valid", {63'd0, m_valid}, 64'd0);
        chk("t6_s_ready", {63'd0, s_ready}, 64'd1);
        chk("t6_level", {61'd0, level}, 64'd0);
        chk("t6_pkt", {61'd0, pkt_count}, 64'd0);
        chk("t6_afull", {63'd0, almost_full}, 64'd0);
        s_valid = 1'b1; s_data = 32'h60; m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        chk("t6_first_data", {32'd0, m_data}, 64'h60);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
